// File: rtl/etapa_if_pkg.sv
// Shared constants for the instruction-fetch stage: next-PC select codes,
// reset/flush values and the fetch FSM state encoding.
package etapa_if_pkg;

  localparam logic [1:0]  SEL_PC4  = 2'b00;
  localparam logic [1:0]  SEL_JUMP = 2'b01;
  localparam logic [1:0]  SEL_JR   = 2'b10;
  localparam logic [1:0]  SEL_ALT4 = 2'b11;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ARRANQUE = 2'b00,
    CORRE    = 2'b01,
    ESPERA   = 2'b10
  } state_t;

endpackage

// File: rtl/etapa_if_sumador_pc.sv
// Sequential-PC adder: PC + 4, wrapping naturally modulo 2^32.
module sumador_pc (
  input  logic [31:0] pc,
  output logic [31:0] pc4
);

  assign pc4 = pc + 32'd4;

endmodule

// File: rtl/etapa_if.sv
// Instruction fetch stage with IF/ID pipeline register, redirect/flush
// handling and a three-state start/run/wait controller.
module etapa_if
  import etapa_if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  SEL_DIR,
  input  logic        resetIF,
  input  logic        stall,
  input  logic [31:0] jr_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic        MEM_RD_I,
  output logic [31:0] pc4_if_id,
  output logic [31:0] instr_if_id,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        valid_if_id,
  output logic [31:0] fetch_count
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        redirect;
  logic        advance;
  logic        accept;

  sumador_pc u_sumador_pc (
    .pc  (pc),
    .pc4 (pc4)
  );

  // Redirect targets come from the instruction currently held in ID.
  assign jump_target = {pc4_if_id[31:28], instr_if_id[25:0], 2'b00};
  assign jr_target   = {jr_addr[31:2], 2'b00};

  always_comb begin
    next_pc  = pc4;
    redirect = 1'b0;
    case (SEL_DIR)
      SEL_JUMP: begin
        next_pc  = jump_target;
        redirect = 1'b1;
      end
      SEL_JR: begin
        next_pc  = jr_target;
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

  // Stall outranks both redirect and flush, so the ID redirect re-issues later.
  assign advance = (state != ARRANQUE) && !stall;
  assign accept  = !resetIF && !redirect;

  assign imem_addr = pc;
  assign opcode    = instr_if_id[31:26];
  assign funct     = instr_if_id[5:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARRANQUE;
      MEM_RD_I    <= 1'b1;
      pc          <= RESET_PC;
      pc4_if_id   <= 32'h0;
      instr_if_id <= NOP_WORD;
      valid_if_id <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        ARRANQUE: begin
          state    <= CORRE;
          MEM_RD_I <= 1'b0;
        end
        CORRE: begin
          if (stall) state <= ESPERA;
        end
        ESPERA: begin
          if (!stall) state <= CORRE;
        end
        default: begin
          state    <= ARRANQUE;
          MEM_RD_I <= 1'b1;
        end
      endcase

      if (advance) begin
        pc <= next_pc;
        if (accept) begin
          pc4_if_id   <= pc4;
          instr_if_id <= imem_data;
          valid_if_id <= 1'b1;
          fetch_count <= fetch_count + 32'd1;
        end else begin
          pc4_if_id   <= 32'h0;
          instr_if_id <= NOP_WORD;
          valid_if_id <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_etapa_if.sv
// Self-checking bench for etapa_if: directed scenarios plus a randomized run
// compared every cycle against a behavioural fetch-stage model.
module tb_etapa_if;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  SEL_DIR;
  logic        resetIF;
  logic        stall;
  logic [31:0] jr_addr;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic        MEM_RD_I;
  logic [31:0] pc4_if_id;
  logic [31:0] instr_if_id;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        valid_if_id;
  logic [31:0] fetch_count;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_pc4, m_instr, m_count;
  logic        m_valid, m_boot;

  always #5 clk = ~clk;

  etapa_if dut (
    .clk         (clk),
    .reset       (reset),
    .SEL_DIR     (SEL_DIR),
    .resetIF     (resetIF),
    .stall       (stall),
    .jr_addr     (jr_addr),
    .imem_data   (imem_data),
    .imem_addr   (imem_addr),
    .MEM_RD_I    (MEM_RD_I),
    .pc4_if_id   (pc4_if_id),
    .instr_if_id (instr_if_id),
    .opcode      (opcode),
    .funct       (funct),
    .valid_if_id (valid_if_id),
    .fetch_count (fetch_count)
  );

  // Instruction memory contents: a few fixed words, hashed elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h2008_0001;
    if (a == 32'h4000_0004) return 32'h0800_0010;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imem_data = mem_word(imem_addr);

  // One clock of the fetch stage as described in words: reset clears all,
  // the first cycle after reset fetches nothing, a stall freezes everything,
  // otherwise PC moves on and IF/ID takes the fetched word or a bubble.
  task automatic model_step();
    logic [31:0] target;
    logic        taken;
    if (reset) begin
      m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_count = 0; m_boot = 1;
      return;
    end
    if (m_boot) begin
      m_boot = 0;
      return;
    end
    if (stall) return;
    taken = (SEL_DIR == 2'd1) || (SEL_DIR == 2'd2);
    if (SEL_DIR == 2'd1)      target = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
    else if (SEL_DIR == 2'd2) target = jr_addr & ~32'd3;
    else                      target = m_pc + 4;
    if (resetIF || taken) begin
      m_pc4 = 0; m_instr = 0; m_valid = 0;
    end else begin
      m_pc4 = m_pc + 4; m_instr = mem_word(m_pc); m_valid = 1; m_count = m_count + 1;
    end
    m_pc = target;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    SEL_DIR = 2'b00; resetIF = 0; stall = 0; jr_addr = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    step(); step();
    reset = 0;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_pc: got %h want 00000000", imem_addr); else n_pass++;
    n_total++; if (MEM_RD_I !== 1'b1) $display("FAIL reset_mem_rd: got %b want 1", MEM_RD_I); else n_pass++;
    n_total++; if ({pc4_if_id, instr_if_id} !== 64'h0) $display("FAIL reset_ifid: got %h want 0", {pc4_if_id, instr_if_id}); else n_pass++;
    n_total++; if ({valid_if_id, fetch_count} !== 33'h0) $display("FAIL reset_valid_count: got %h want 0", {valid_if_id, fetch_count}); else n_pass++;
  endtask

  task automatic test_first_fetch();
    step();
    n_total++; if (MEM_RD_I !== 1'b0) $display("FAIL start_mem_rd: got %b want 0", MEM_RD_I); else n_pass++;
    n_total++; if (valid_if_id !== 1'b0 || imem_addr !== 32'h0) $display("FAIL start_hold: got v=%b pc=%h want v=0 pc=0", valid_if_id, imem_addr); else n_pass++;
    step();
    n_total++; if (instr_if_id !== 32'h2008_0001) $display("FAIL first_instr: got %h want 20080001", instr_if_id); else n_pass++;
    n_total++; if (pc4_if_id !== 32'h4) $display("FAIL first_pc4: got %h want 00000004", pc4_if_id); else n_pass++;
    n_total++; if (valid_if_id !== 1'b1 || fetch_count !== 32'd1) $display("FAIL first_count: got v=%b c=%0d want v=1 c=1", valid_if_id, fetch_count); else n_pass++;
    n_total++; if (opcode !== 6'h08 || funct !== 6'h01) $display("FAIL first_fields: got op=%h fn=%h want 08 01", opcode, funct); else n_pass++;
  endtask

  task automatic test_jump();
    logic [31:0] cnt;
    SEL_DIR = 2'b10; jr_addr = 32'h4000_0004; step();
    SEL_DIR = 2'b00; step();
    n_total++; if (instr_if_id !== 32'h0800_0010 || pc4_if_id !== 32'h4000_0008) $display("FAIL jump_setup: got %h/%h want 08000010/40000008", instr_if_id, pc4_if_id); else n_pass++;
    cnt = m_count;
    SEL_DIR = 2'b01; step();
    SEL_DIR = 2'b00;
    n_total++; if (imem_addr !== 32'h4000_0040) $display("FAIL jump_pc: got %h want 40000040", imem_addr); else n_pass++;
    n_total++; if (instr_if_id !== 32'h0 || pc4_if_id !== 32'h0 || valid_if_id !== 1'b0) $display("FAIL jump_flush: got %h/%h/%b want 0/0/0", instr_if_id, pc4_if_id, valid_if_id); else n_pass++;
    n_total++; if (fetch_count !== cnt) $display("FAIL jump_count: got %0d want %0d", fetch_count, cnt); else n_pass++;
  endtask

  task automatic test_jr();
    SEL_DIR = 2'b10; jr_addr = 32'h0000_1237; step();
    SEL_DIR = 2'b00;
    n_total++; if (imem_addr !== 32'h0000_1234) $display("FAIL jr_pc: got %h want 00001234", imem_addr); else n_pass++;
    n_total++; if (valid_if_id !== 1'b0 || instr_if_id !== 32'h0) $display("FAIL jr_flush: got v=%b i=%h want 0/0", valid_if_id, instr_if_id); else n_pass++;
    resetIF = 1; step(); resetIF = 0;
    n_total++; if (imem_addr !== 32'h0000_1238 || valid_if_id !== 1'b0) $display("FAIL resetif: got pc=%h v=%b want 00001238/0", imem_addr, valid_if_id); else n_pass++;
    SEL_DIR = 2'b11; step(); SEL_DIR = 2'b00;
    n_total++; if (imem_addr !== 32'h0000_123C || instr_if_id !== mem_word(32'h1238)) $display("FAIL sel11: got pc=%h i=%h want 0000123c/%h", imem_addr, instr_if_id, mem_word(32'h1238)); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] pc_hold, i_hold, c_hold;
    step();
    pc_hold = m_pc; i_hold = m_instr; c_hold = m_count;
    stall = 1; SEL_DIR = 2'b01; resetIF = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++; if (imem_addr !== pc_hold || instr_if_id !== i_hold || fetch_count !== c_hold)
        $display("FAIL stall_hold%0d: got %h/%h/%0d want %h/%h/%0d", k, imem_addr, instr_if_id, fetch_count, pc_hold, i_hold, c_hold);
      else n_pass++;
      n_total++; if (MEM_RD_I !== 1'b0) $display("FAIL stall_mem_rd%0d: got %b want 0", k, MEM_RD_I); else n_pass++;
    end
    stall = 0; resetIF = 0; step(); SEL_DIR = 2'b00;
    n_total++; if (imem_addr !== m_pc || valid_if_id !== 1'b0) $display("FAIL stall_redirect: got pc=%h v=%b want %h/0", imem_addr, valid_if_id, m_pc); else n_pass++;
  endtask

  task automatic test_wrap();
    SEL_DIR = 2'b10; jr_addr = 32'hFFFF_FFFF; step();
    n_total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_setup: got %h want fffffffc", imem_addr); else n_pass++;
    SEL_DIR = 2'b00; step();
    n_total++; if (imem_addr !== 32'h0 || pc4_if_id !== 32'h0 || valid_if_id !== 1'b1) $display("FAIL wrap: got pc=%h pc4=%h v=%b want 0/0/1", imem_addr, pc4_if_id, valid_if_id); else n_pass++;
  endtask

  task automatic test_reset_in_stall();
    SEL_DIR = 2'b10; jr_addr = 32'h0000_0100; step();
    SEL_DIR = 2'b00; stall = 1; step(); step();
    n_total++; if (imem_addr !== 32'h100) $display("FAIL rst_stall_setup: got %h want 00000100", imem_addr); else n_pass++;
    reset = 1; SEL_DIR = 2'b01; resetIF = 1; step();
    reset = 0; idle_inputs();
    n_total++; if (imem_addr !== 32'h0 || MEM_RD_I !== 1'b1) $display("FAIL rst_stall_pc: got pc=%h rd=%b want 0/1", imem_addr, MEM_RD_I); else n_pass++;
    n_total++; if ({pc4_if_id, instr_if_id, valid_if_id, fetch_count} !== 97'h0) $display("FAIL rst_stall_regs: got %h want 0", {pc4_if_id, instr_if_id, valid_if_id, fetch_count}); else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      SEL_DIR = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) SEL_DIR = 2'b00;
      resetIF = ($urandom_range(0, 7) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 63) == 0);
      jr_addr = $urandom;
      step();
      n_total++; if (imem_addr !== m_pc) $display("FAIL rand_pc@%0d: got %h want %h", k, imem_addr, m_pc); else n_pass++;
      n_total++; if (MEM_RD_I !== m_boot) $display("FAIL rand_mem_rd@%0d: got %b want %b", k, MEM_RD_I, m_boot); else n_pass++;
      n_total++; if (instr_if_id !== m_instr || pc4_if_id !== m_pc4) $display("FAIL rand_ifid@%0d: got %h/%h want %h/%h", k, instr_if_id, pc4_if_id, m_instr, m_pc4); else n_pass++;
      n_total++; if (valid_if_id !== m_valid || fetch_count !== m_count) $display("FAIL rand_count@%0d: got %b/%0d want %b/%0d", k, valid_if_id, fetch_count, m_valid, m_count); else n_pass++;
      n_total++; if (opcode !== m_instr[31:26] || funct !== m_instr[5:0]) $display("FAIL rand_fields@%0d: got %h/%h want %h/%h", k, opcode, funct, m_instr[31:26], m_instr[5:0]); else n_pass++;
    end
    reset = 0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_jump();
    test_jr();
    test_stall();
    test_wrap();
    test_reset_in_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
